// File: rtl/bulls_cows_param.sv
// Multi-player Bulls and Cows game controller: secret entry, turn scoring,
// round counting and win/draw detection, all outputs registered.
module bulls_cows_param #(
   parameter int N_DIGITS   = 4,
   parameter int DIGIT_W    = 4,
   parameter int MAX_DIGIT  = 9,
   parameter int N_PLAYERS  = 2,
   parameter int MAX_ROUNDS = 8,
   localparam int PW = ($clog2(N_PLAYERS) > 1) ? $clog2(N_PLAYERS) : 1,
   localparam int CW = $clog2(N_DIGITS + 1),
   localparam int RW = ($clog2(MAX_ROUNDS + 1) > 1) ? $clog2(MAX_ROUNDS + 1) : 1,
   localparam int SW_W = N_DIGITS * DIGIT_W
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [SW_W-1:0]      sw,
   input  logic                 enter,
   output logic [2:0]           state,
   output logic [PW-1:0]        player,
   output logic [CW-1:0]        bulls,
   output logic [CW-1:0]        cows,
   output logic [RW-1:0]        round,
   output logic                 reject,
   output logic [N_PLAYERS-1:0] win
);

   typedef enum logic [2:0] {
      S_SETUP  = 3'd0,
      S_TURN   = 3'd1,
      S_RESULT = 3'd2,
      S_WIN    = 3'd3,
      S_DRAW   = 3'd4
   } game_state_t;

   localparam logic [DIGIT_W-1:0] MAX_D     = DIGIT_W'(MAX_DIGIT);
   localparam logic [PW-1:0]      LAST_P    = PW'(N_PLAYERS - 1);
   localparam logic [CW-1:0]      ALL_BULLS = CW'(N_DIGITS);
   localparam logic [RW-1:0]      ROUND_LIM = RW'(MAX_ROUNDS);
   localparam logic [RW-1:0]      ROUND_TOP = {RW{1'b1}};

   game_state_t            state_q, state_d;
   logic [PW-1:0]          player_q, player_d;
   logic [RW-1:0]          round_q, round_d, round_inc;
   logic [CW-1:0]          bulls_q, bulls_d, cows_q, cows_d;
   logic [CW-1:0]          bulls_n, cows_n;
   logic                   reject_q, reject_d;
   logic [N_PLAYERS-1:0]   win_q, win_d;
   logic [SW_W-1:0]        secret_q [N_PLAYERS];
   logic [SW_W-1:0]        target;
   logic [PW-1:0]          target_idx;
   logic                   enter_q;
   logic                   rise;
   logic                   entry_ok;
   logic                   secret_we;
   logic                   clear_all;

   // enter_q powers up high so a button held through reset is not a press.
   assign rise = enter & ~enter_q;

   assign target_idx = (player_q == LAST_P) ? '0 : player_q + PW'(1);
   assign target     = secret_q[target_idx];
   assign round_inc  = (round_q == ROUND_TOP) ? round_q : round_q + RW'(1);

   always_comb begin : validity
      entry_ok = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (sw[i*DIGIT_W +: DIGIT_W] > MAX_D) entry_ok = 1'b0;
         for (int j = i + 1; j < N_DIGITS; j++) begin
            if (sw[i*DIGIT_W +: DIGIT_W] == sw[j*DIGIT_W +: DIGIT_W]) entry_ok = 1'b0;
         end
      end
   end

   // Same position scores a bull, any other position holding the digit a cow.
   always_comb begin : scoring
      bulls_n = '0;
      cows_n  = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         for (int j = 0; j < N_DIGITS; j++) begin
            if (target[i*DIGIT_W +: DIGIT_W] == sw[j*DIGIT_W +: DIGIT_W]) begin
               if (i == j) bulls_n = bulls_n + CW'(1);
               else        cows_n  = cows_n + CW'(1);
            end
         end
      end
   end

   always_comb begin : next_state
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      player_d  = player_q;
      round_d   = round_q;
      bulls_d   = bulls_q;
      cows_d    = cows_q;
      win_d     = win_q;
      reject_d  = 1'b0;
      secret_we = 1'b0;
      clear_all = 1'b0;

      case (state_q)
         S_SETUP: begin
            if (rise) begin
               if (!entry_ok) begin
                  reject_d = 1'b1;
               end else begin
                  secret_we = 1'b1;
                  if (player_q == LAST_P) begin
                     state_d  = S_TURN;
                     player_d = '0;
                     round_d  = '0;
                  end else begin
                     player_d = player_q + PW'(1);
                  end
               end
            end
         end

         S_TURN: begin
            if (rise) begin
               if (!entry_ok) begin
                  reject_d = 1'b1;
               end else begin
                  bulls_d = bulls_n;
                  cows_d  = cows_n;
                  if (bulls_n == ALL_BULLS) begin
                     state_d         = S_WIN;
                     win_d           = '0;
                     win_d[player_q] = 1'b1;
                  end else begin
                     state_d = S_RESULT;
                  end
               end
            end
         end

         S_RESULT: begin
            if (rise) begin
               bulls_d = '0;
               cows_d  = '0;
               if (player_q != LAST_P) begin
                  state_d  = S_TURN;
                  player_d = player_q + PW'(1);
               end else begin
                  round_d = round_inc;
                  if ((MAX_ROUNDS != 0) && (round_inc == ROUND_LIM)) begin
                     state_d = S_DRAW;
                  end else begin
                     state_d  = S_TURN;
                     player_d = '0;
                  end
               end
            end
         end

         S_WIN, S_DRAW: begin
            if (rise) begin
               state_d   = S_SETUP;
               player_d  = '0;
               round_d   = '0;
               bulls_d   = '0;
               cows_d    = '0;
               win_d     = '0;
               clear_all = 1'b1;
            end
         end

         default: state_d = S_SETUP;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_SETUP;
         player_q <= '0;
         round_q  <= '0;
         bulls_q  <= '0;
         cows_q   <= '0;
         reject_q <= 1'b0;
         win_q    <= '0;
         enter_q  <= 1'b1;
         // NOTE: the secret store is reset explicitly because a fresh game must never score against a stale code.
         for (int k = 0; k < N_PLAYERS; k++) secret_q[k] <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the pre-edge values computed above.
         state_q  <= state_d;
         player_q <= player_d;
         round_q  <= round_d;
         bulls_q  <= bulls_d;
         cows_q   <= cows_d;
         reject_q <= reject_d;
         win_q    <= win_d;
         enter_q  <= enter;
         if (clear_all) begin
            for (int k = 0; k < N_PLAYERS; k++) secret_q[k] <= '0;
         end else if (secret_we) begin
            secret_q[player_q] <= sw;
         end
      end
   end

   assign state  = state_q;
   assign player = player_q;
   assign round  = round_q;
   assign bulls  = bulls_q;
   assign cows   = cows_q;
   assign reject = reject_q;
   assign win    = win_q;

endmodule
